// File: rtl/seq_pattern_detector.sv
// Parametrised serial pattern detector with runtime-loadable pattern and overlap mode.
// Optional saturating match counter enabled by defining SEQDET_COUNT_EN.
module seq_pattern_detector #(
   parameter int                 PAT_LEN = 3,
   parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         x_valid,
   input  logic                         x,
   input  logic                         cfg_load,
   input  logic [PAT_LEN-1:0]           cfg_pattern,
   input  logic                         cfg_overlap,
   input  logic                         cnt_clr,
   output logic                         match,
   output logic [$clog2(PAT_LEN+1)-1:0] fill,
   output logic [CNT_W-1:0]             match_count
);

   localparam int                FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

   logic [PAT_LEN-1:0] r_hist;
   logic [FILL_W-1:0]  r_fill;
   logic [PAT_LEN-1:0] r_pat;
   logic               r_ovl;
   logic               r_match;

   logic [PAT_LEN-1:0] w_hist_n;
   logic [FILL_W-1:0]  w_fill_inc;
   logic [FILL_W-1:0]  w_fill_nxt;
   logic               w_hit;
   logic               w_match_n;

   // State register: fill is the FSM state (0 empty, 1..PAT_LEN-1 partial, PAT_LEN full)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hist  <= '0;
         r_fill  <= '0;
         r_pat   <= PATTERN;
         r_ovl   <= OVERLAP;
         r_match <= 1'b0;
      end else begin
         r_fill  <= w_fill_nxt;
         r_match <= w_match_n;
         if (cfg_load) begin
            r_pat <= cfg_pattern;
            r_ovl <= cfg_overlap;
         end else if (x_valid) begin
            r_hist <= w_hist_n;
         end
      end
   end

   // Next state; matching is gated by fill so stale history never produces a hit
   always_comb begin
      w_hist_n   = {r_hist[PAT_LEN-2:0], x};
      w_fill_inc = (r_fill == FULL) ? FULL : r_fill + FILL_W'(1);
      w_hit      = x_valid && !cfg_load && (w_fill_inc == FULL) && (w_hist_n == r_pat);
      w_fill_nxt = r_fill;
      if (cfg_load) begin
         w_fill_nxt = '0;
      end else if (x_valid) begin
         w_fill_nxt = (w_hit && !r_ovl) ? '0 : w_fill_inc;
      end
   end

   always_comb begin
      w_match_n = w_hit;
   end

   assign match = r_match;
   assign fill  = r_fill;

`ifdef SEQDET_COUNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [CNT_W-1:0] r_cnt;

   // A clear coinciding with a hit counts that hit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= w_hit ? CNT_W'(1) : '0;
      end else if (w_hit) begin
         r_cnt <= sat_inc(r_cnt);
      end
   end

   assign match_count = r_cnt;
`else
   logic w_unused_cnt_clr;
   assign w_unused_cnt_clr = cnt_clr;
   assign match_count      = '0;
`endif

endmodule
